// File: rtl/uart_dma_ctrl_pkg.sv
// Shared FSM encoding, default UART register map and channel event type for
// the UART DMA controller.
package uart_dma_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_MEM_RD     = 3'd1,
        ST_MEM_WAIT   = 3'd2,
        ST_APB_SETUP  = 3'd3,
        ST_APB_ACCESS = 3'd4,
        ST_MEM_WR     = 3'd5
    } dma_state_e;

    localparam logic [3:0] DEF_TX_DATA_ADDR = 4'h0;
    localparam logic [3:0] DEF_RX_DATA_ADDR = 4'h1;

    // Per-channel transfer outcome, raised for one cycle by the top-level FSM.
    typedef struct packed {
        logic ok;
        logic err;
    } xfer_evt_t;

    function automatic logic is_apb_phase(input dma_state_e s);
        return (s == ST_APB_SETUP) || (s == ST_APB_ACCESS);
    endfunction

endpackage

// File: rtl/uart_dma_ctrl_if.sv
// APB master bus towards the UART plus the SRAM-style memory port, bundled so
// the DMA engine and its environment share one connection.
interface uart_dma_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_AW     = 10
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [MEM_AW-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output PADDR, PSELx, PENABLE, PWRITE, PWDATA,
        output mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        input  PREADY, PRDATA, PSLVERR, mem_rdata
    );

    modport slave (
        input  PADDR, PSELx, PENABLE, PWRITE, PWDATA,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        output PREADY, PRDATA, PSLVERR, mem_rdata
    );
endinterface

// File: rtl/uart_dma_ctrl_chan_cnt.sv
// One DMA channel's bookkeeping: latches base/length on start, walks the
// address (wrapping), counts bytes down and reports active/done/err.
module dma_chan_cnt
    import uart_dma_ctrl_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              start,
    input  logic [MEM_AW-1:0] base,
    input  logic [MEM_AW-1:0] len,
    input  xfer_evt_t         evt,
    output logic              active,
    output logic              done,
    output logic              err,
    output logic [MEM_AW-1:0] addr
);
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [MEM_AW-1:0] remain_q, remain_d;

    always_comb begin
        active_d = active_q;
        done_d   = 1'b0;
        err_d    = err_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        // Transfer events only occur while active, so a start that is accepted
        // never collides with one.
        if (start && !active_q) begin
            err_d = 1'b0;
            if (len == '0) begin
                done_d = 1'b1;
            end else begin
                active_d = 1'b1;
                addr_d   = base;
                remain_d = len;
            end
        end else if (evt.err) begin
            active_d = 1'b0;
            err_d    = 1'b1;
        end else if (evt.ok) begin
            addr_d   = addr_q + MEM_AW'(1);
            remain_d = remain_q - MEM_AW'(1);
            if (remain_q == MEM_AW'(1)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge value of its _d regardless of process ordering.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            active_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            active_q <= active_d;
            done_q   <= done_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
        end
    end

    assign active = active_q;
    assign done   = done_q;
    assign err    = err_q;
    assign addr   = addr_q;

endmodule

// File: rtl/uart_dma_ctrl.sv
// DMA engine in front of the APB UART: moves bytes memory->UART TX data
// register and UART RX data register->memory, one APB transfer at a time.
module uart_dma_ctrl
    import uart_dma_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 4,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    MEM_AW       = 10,
    parameter logic [ADDR_WIDTH-1:0] TX_DATA_ADDR = ADDR_WIDTH'(DEF_TX_DATA_ADDR),
    parameter logic [ADDR_WIDTH-1:0] RX_DATA_ADDR = ADDR_WIDTH'(DEF_RX_DATA_ADDR)
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              tx_start,
    input  logic [MEM_AW-1:0] tx_base,
    input  logic [MEM_AW-1:0] tx_len,
    input  logic              rx_start,
    input  logic [MEM_AW-1:0] rx_base,
    input  logic [MEM_AW-1:0] rx_len,
    output logic              tx_active,
    output logic              rx_active,
    output logic              tx_done,
    output logic              rx_done,
    output logic              tx_err,
    output logic              rx_err,
    input  logic              dma_tx_req,
    input  logic              dma_rx_req,
    uart_dma_ctrl_if.master   bus
);
    dma_state_e            state_q, state_d;
    logic                  sel_rx_q, sel_rx_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [MEM_AW-1:0]     tx_addr, rx_addr;
    xfer_evt_t             tx_evt, rx_evt;

    dma_chan_cnt #(.MEM_AW(MEM_AW)) u_tx_cnt (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .start   (tx_start),
        .base    (tx_base),
        .len     (tx_len),
        .evt     (tx_evt),
        .active  (tx_active),
        .done    (tx_done),
        .err     (tx_err),
        .addr    (tx_addr)
    );

    dma_chan_cnt #(.MEM_AW(MEM_AW)) u_rx_cnt (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .start   (rx_start),
        .base    (rx_base),
        .len     (rx_len),
        .evt     (rx_evt),
        .active  (rx_active),
        .done    (rx_done),
        .err     (rx_err),
        .addr    (rx_addr)
    );

    // NOTE: all control and bus registers are reset; this block holds no
    // storage array, so nothing is left to power up undefined.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= ST_IDLE;
            sel_rx_q <= 1'b0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            sel_rx_q <= sel_rx_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        sel_rx_d = sel_rx_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            // RX wins to keep the UART receive FIFO from overrunning.
            ST_IDLE: begin
                if (rx_active && dma_rx_req) begin
                    state_d  = ST_APB_SETUP;
                    sel_rx_d = 1'b1;
                    paddr_d  = RX_DATA_ADDR;
                    pwrite_d = 1'b0;
                end else if (tx_active && dma_tx_req) begin
                    state_d  = ST_MEM_RD;
                    sel_rx_d = 1'b0;
                end
            end
            ST_MEM_RD: state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                state_d  = ST_APB_SETUP;
                pwdata_d = bus.mem_rdata;
                paddr_d  = TX_DATA_ADDR;
                pwrite_d = 1'b1;
            end
            ST_APB_SETUP: state_d = ST_APB_ACCESS;
            ST_APB_ACCESS: begin
                if (bus.PREADY) begin
                    if (sel_rx_q) begin
                        rdata_d = bus.PRDATA;
                        state_d = bus.PSLVERR ? ST_IDLE : ST_MEM_WR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_MEM_WR: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // RX bookkeeping advances as MEM_WR retires so rx_addr still points at the
    // byte being written during that cycle.
    always_comb begin
        bus.PSELx     = is_apb_phase(state_q);
        bus.PENABLE   = (state_q == ST_APB_ACCESS);
        bus.mem_rd_en = 1'b0;
        bus.mem_wr_en = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        tx_evt        = '0;
        rx_evt        = '0;
        unique case (state_q)
            ST_MEM_RD: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = tx_addr;
            end
            ST_APB_ACCESS: begin
                if (bus.PREADY) begin
                    if (sel_rx_q) begin
                        rx_evt.err = bus.PSLVERR;
                    end else begin
                        tx_evt.ok  = !bus.PSLVERR;
                        tx_evt.err = bus.PSLVERR;
                    end
                end
            end
            ST_MEM_WR: begin
                bus.mem_wr_en = 1'b1;
                bus.mem_addr  = rx_addr;
                bus.mem_wdata = rdata_q;
                rx_evt.ok     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.PADDR  = paddr_q;
    assign bus.PWRITE = pwrite_q;
    assign bus.PWDATA = pwdata_q;

endmodule
